// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - data RAM, LED/switch/display/counter registers behind the core's data port
// Word-addressed decode on ALUResult; ReadData is combinational, all state changes on CLK.
module mem_io_bridge #(
  parameter int RAM_AW   = 8,
  parameter int LED_W    = 16,
  parameter int SW_W     = 16,
  parameter int SCAN_DIV = 100000
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             MemWrite,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      WriteData,
  input  logic [SW_W-1:0]  Switch,
  output logic [31:0]      ReadData,
  output logic [LED_W-1:0] LED,
  output logic [7:0]       AN,
  output logic [6:0]       CA
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [31:0]       ram_q [0:(1<<RAM_AW)-1];
  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       disp_q, disp_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
  logic [PW-1:0]     pre_q, pre_d;
  logic [2:0]        digit_q, digit_d;
  logic [7:0]        an_q, an_d;
  logic [6:0]        ca_q, ca_d;

  logic [31:0]       addr_w;
  logic [RAM_AW-1:0] ram_idx;
  logic              sel_ram, sel_led, sel_sw, sel_disp, sel_cnt;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^ALUResult[1:0];
  assign addr_w   = {ALUResult[31:2], 2'b00};
  assign ram_idx  = ALUResult[RAM_AW+1:2];
  assign sel_ram  = (ALUResult[31:10] == 22'h000004);
  assign sel_led  = (addr_w == 32'h0000_2000);
  assign sel_sw   = (addr_w == 32'h0000_2004);
  assign sel_disp = (addr_w == 32'h0000_2008);
  assign sel_cnt  = (addr_w == 32'h0000_200C);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    ReadData = 32'h0;
    if (sel_ram)       ReadData = ram_q[ram_idx];
    else if (sel_led)  ReadData = 32'(led_q);
    else if (sel_sw)   ReadData = 32'(sw_sync_q);
    else if (sel_disp) ReadData = disp_q;
    else if (sel_cnt)  ReadData = cnt_q;
  end

  always_comb begin
    led_d   = (MemWrite && sel_led)  ? WriteData[LED_W-1:0] : led_q;
    disp_d  = (MemWrite && sel_disp) ? WriteData : disp_q;
    // A clearing write takes priority over the free-running increment.
    cnt_d   = (MemWrite && sel_cnt)  ? 32'h0 : cnt_q + 32'd1;
    pre_d   = pre_q + 1'b1;
    digit_d = digit_q;
    if (pre_q == PW'(SCAN_DIV - 1)) begin
      pre_d   = '0;
      digit_d = digit_q + 3'd1;
    end
    an_d = ~(8'd1 << digit_q);
    ca_d = hex7(disp_q[{digit_q, 2'b00} +: 4]);
  end

  always_ff @(posedge CLK) begin
    if (MemWrite && sel_ram) ram_q[ram_idx] <= WriteData;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      led_q     <= '0;
      disp_q    <= 32'h0;
      cnt_q     <= 32'h0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      pre_q     <= '0;
      digit_q   <= 3'd0;
      an_q      <= 8'hFE;
      ca_q      <= 7'h40;
    end else begin
      led_q     <= led_d;
      disp_q    <= disp_d;
      cnt_q     <= cnt_d;
      sw_meta_q <= Switch;
      sw_sync_q <= sw_meta_q;
      pre_q     <= pre_d;
      digit_q   <= digit_d;
      an_q      <= an_d;
      ca_q      <= ca_d;
    end
  end

  assign LED = led_q;
  assign AN  = an_q;
  assign CA  = ca_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb/tb_mem_io_bridge.sv - directed plus randomized bench for mem_io_bridge
// Expected values come from a behavioural model of the memory map and scanner timing.
module tb_mem_io_bridge;

  localparam int SCAN = 4;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] ALUResult = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [15:0] Switch = 16'h0;
  logic [31:0] ReadData;
  logic [15:0] LED;
  logic [7:0]  AN;
  logic [6:0]  CA;

  int tests = 0;
  int failed = 0;

  mem_io_bridge #(.RAM_AW(8), .LED_W(16), .SW_W(16), .SCAN_DIV(SCAN)) dut (
    .CLK(CLK), .Reset(Reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .Switch(Switch), .ReadData(ReadData),
    .LED(LED), .AN(AN), .CA(CA)
  );

  always #5 CLK = ~CLK;

  logic [6:0] seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [31:0] ram_ref [256];
  bit          ram_ok [256];
  logic [15:0] led_ref, sw1, sw2;
  logic [31:0] disp_ref, cnt_ref;
  logic [7:0]  an_ref;
  logic [6:0]  ca_ref;
  int          nedge;

  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      led_ref = 16'h0; disp_ref = 32'h0; cnt_ref = 32'h0;
      sw1 = 16'h0; sw2 = 16'h0; nedge = 0;
      an_ref = 8'hFE; ca_ref = 7'h40;
    end else begin
      int dig;
      logic [31:0] aw;
      dig = (nedge / SCAN) % 8;
      an_ref = ~(8'd1 << dig);
      ca_ref = seg[disp_ref[dig*4 +: 4]];
      nedge++;
      sw2 = sw1;
      sw1 = Switch;
      aw = ALUResult & ~32'h3;
      cnt_ref = (MemWrite && aw == 32'h200C) ? 32'h0 : cnt_ref + 32'd1;
      if (MemWrite) begin
        if (aw >= 32'h1000 && aw <= 32'h13FC) begin
          ram_ref[(aw - 32'h1000) / 4] = WriteData;
          ram_ok[(aw - 32'h1000) / 4] = 1'b1;
        end else if (aw == 32'h2000) led_ref = WriteData[15:0];
        else if (aw == 32'h2008) disp_ref = WriteData;
      end
    end
  end

  function automatic logic [31:0] mread(input logic [31:0] a, output bit known);
    logic [31:0] aw;
    aw = a & ~32'h3;
    known = 1'b1;
    if (aw >= 32'h1000 && aw <= 32'h13FC) begin
      known = ram_ok[(aw - 32'h1000) / 4];
      return ram_ref[(aw - 32'h1000) / 4];
    end
    case (aw)
      32'h2000: return {16'h0, led_ref};
      32'h2004: return {16'h0, sw2};
      32'h2008: return disp_ref;
      32'h200C: return cnt_ref;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp;
    bit known;
    @(negedge CLK);
    MemWrite = we; ALUResult = a; WriteData = d;
    #1;
    exp = mread(a, known);
    if (known) check("read", ReadData, exp);
    check("led", {16'h0, LED}, {16'h0, led_ref});
    check("an", {24'h0, AN}, {24'h0, an_ref});
    check("ca", {25'h0, CA}, {25'h0, ca_ref});
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1: return 32'h1000 + {$urandom_range(0, 7), 2'b00} + 32'($urandom_range(0, 3));
      2: return 32'h2000 + 32'($urandom_range(0, 3));
      3: return 32'h2004;
      4: return 32'h2008;
      5: return 32'h200C;
      6: begin
        logic [31:0] edges [4] = '{32'h0FFC, 32'h1400, 32'h2010, 32'h3000};
        return edges[$urandom_range(0, 3)];
      end
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    // Reset state
    #12;
    ALUResult = 32'h2000; #1; check("rst_led_rd", ReadData, 32'h0);
    ALUResult = 32'h2008; #1; check("rst_disp_rd", ReadData, 32'h0);
    ALUResult = 32'h2004; #1; check("rst_sw_rd", ReadData, 32'h0);
    check("rst_an", {24'h0, AN}, 32'hFE);
    check("rst_ca", {25'h0, CA}, 32'h40);
    @(negedge CLK); @(negedge CLK);
    Reset = 1'b1; ALUResult = 32'h200C; #1;
    check("cnt_start", ReadData, 32'h0);
    cyc(0, 32'h200C, 0); check("cnt_up1", ReadData, 32'h1);
    cyc(0, 32'h200C, 0); check("cnt_up2", ReadData, 32'h2);

    // RAM
    cyc(1, 32'h1004, 32'hDEADBEEF);
    cyc(1, 32'h13FC, 32'h12345678);
    cyc(0, 32'h1004, 0); check("ram_1004", ReadData, 32'hDEADBEEF);
    cyc(0, 32'h13FC, 0); check("ram_13fc", ReadData, 32'h12345678);
    cyc(1, 32'h1004, 32'h0); check("ram_prewrite", ReadData, 32'hDEADBEEF);
    cyc(0, 32'h1004, 0); check("ram_postwrite", ReadData, 32'h0);

    // LED and unmapped
    cyc(1, 32'h2000, 32'hFFFFA5A5);
    cyc(0, 32'h2000, 0); check("led_rd", ReadData, 32'h0000A5A5);
    check("led_port", {16'h0, LED}, 32'hA5A5);
    cyc(1, 32'h3000, 32'hFFFFFFFF);
    cyc(0, 32'h3000, 0); check("unmapped_rd", ReadData, 32'h0);
    cyc(0, 32'h2000, 0); check("led_kept", ReadData, 32'h0000A5A5);

    // Switch synchroniser
    @(negedge CLK); MemWrite = 1'b0; Switch = 16'h00C3; ALUResult = 32'h2004;
    cyc(0, 32'h2004, 0); check("sw_1edge", ReadData, 32'h0);
    cyc(0, 32'h2004, 0); check("sw_2edge", ReadData, 32'h000000C3);
    cyc(1, 32'h2004, 32'hFFFF); cyc(0, 32'h2004, 0); check("sw_ro", ReadData, 32'h000000C3);

    // Counter clear
    cyc(1, 32'h200C, 32'h5);
    cyc(0, 32'h200C, 0); check("clr_0", ReadData, 32'h0);
    cyc(0, 32'h200C, 0); check("clr_1", ReadData, 32'h1);
    cyc(0, 32'h200C, 0); check("clr_2", ReadData, 32'h2);

    // Display scan
    cyc(1, 32'h2008, 32'h012389AF);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      cyc(0, 32'h2008, 0);
      if (!seen && AN == 8'hEF) begin
        seen = 1'b1;
        check("disp_dig4", {25'h0, CA}, 32'h30);
      end
    end
    check("disp_dig4_seen", {31'h0, seen}, 32'h1);

    // Reset mid-scan
    @(negedge CLK); MemWrite = 1'b0; #2 Reset = 1'b0; #1;
    check("mid_rst_an", {24'h0, AN}, 32'hFE);
    check("mid_rst_ca", {25'h0, CA}, 32'h40);
    check("mid_rst_led", {16'h0, LED}, 32'h0);
    @(negedge CLK); Reset = 1'b1;
    cyc(1, 32'h2008, 32'hFEDCBA98);
    for (int i = 0; i < 40; i++) cyc(0, 32'h2000, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) Switch = 16'($urandom);
      cyc(1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
